// File: rtl/edge_stim_if.sv
// edge_stim_if: command handshake and generated-signal bundle for edge_stim_gen
interface edge_stim_if #(
    parameter int WIDTH = 32,
    parameter int DLY_W = 8
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [1:0]               cmd_op;
    logic [$clog2(WIDTH)-1:0] cmd_idx;
    logic [DLY_W-1:0]         cmd_dly;
    logic [DLY_W-1:0]         cmd_hold;
    logic [WIDTH-1:0]         sig_out;
    logic [WIDTH-1:0]         rose_o;
    logic [WIDTH-1:0]         fell_o;
    logic                     done;
    logic                     err;

    modport master (
        output cmd_valid, cmd_op, cmd_idx, cmd_dly, cmd_hold,
        input  cmd_ready, sig_out, rose_o, fell_o, done, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_idx, cmd_dly, cmd_hold,
        output cmd_ready, sig_out, rose_o, fell_o, done, err
    );
endinterface

// File: rtl/edge_stim_gen.sv
// edge_stim_gen: schedules a rise/fall/pulse/toggle on one bit of a bus after a delay
module edge_stim_gen #(
    parameter int               WIDTH = 32,
    parameter int               DLY_W = 8,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input logic        clk,
    input logic        rst,
    edge_stim_if.slave bus
);
    localparam int IW = $clog2(WIDTH);
    localparam logic [1:0] OP_FALL = 2'b01;
    localparam logic [1:0] OP_PULSE = 2'b10;
    localparam logic [1:0] OP_TOG = 2'b11;

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t           state;
    logic [DLY_W-1:0] cnt;
    logic [DLY_W-1:0] hold;
    logic [1:0]       op;
    logic [IW-1:0]    idx;
    logic             bad;
    logic             cur;
    logic             nxt;
    logic             nop;

    assign bus.cmd_ready = (state == IDLE);

    // Target bit's current value, its intended new value, and whether the edge would be a no-op
    always_comb begin
        cur = bus.sig_out[idx];
        nxt = (op == OP_TOG) ? ~cur : (op != OP_FALL);
        nop = (op != OP_TOG) && (cur == nxt);
    end

    // Command FSM: latch on accept, count down the delay, apply the edge, then hold for pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            hold        <= '0;
            op          <= '0;
            idx         <= '0;
            bad         <= 1'b0;
            bus.sig_out <= INIT;
            bus.rose_o  <= '0;
            bus.fell_o  <= '0;
            bus.done    <= 1'b0;
            bus.err     <= 1'b0;
        end else begin
            bus.rose_o <= '0;
            bus.fell_o <= '0;
            bus.done   <= 1'b0;
            bus.err    <= 1'b0;
            case (state)
                IDLE: if (bus.cmd_valid) begin
                    op    <= bus.cmd_op;
                    idx   <= bus.cmd_idx;
                    cnt   <= bus.cmd_dly;
                    hold  <= bus.cmd_hold;
                    bad   <= int'(bus.cmd_idx) >= WIDTH;
                    state <= WAIT;
                end
                WAIT: if (bad || (cnt == '0 && nop)) begin
                    bus.err  <= 1'b1;
                    bus.done <= 1'b1;
                    state    <= IDLE;
                end else if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else begin
                    bus.sig_out[idx] <= nxt;
                    bus.rose_o[idx]  <= nxt & ~cur;
                    bus.fell_o[idx]  <= ~nxt & cur;
                    bus.done         <= (op != OP_PULSE);
                    cnt              <= hold;
                    state            <= (op == OP_PULSE) ? HOLD : IDLE;
                end
                HOLD: if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else begin
                    bus.sig_out[idx] <= 1'b0;
                    bus.fell_o[idx]  <= 1'b1;
                    bus.done         <= 1'b1;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_edge_stim_gen.sv
// tb_edge_stim_gen: directed checks of edge_stim_gen timing, flags, errors and reset
module tb_edge_stim_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;

    edge_stim_if #(.WIDTH(32), .DLY_W(8)) b0 ();
    edge_stim_if #(.WIDTH(24), .DLY_W(8)) b1 ();

    edge_stim_gen #(.WIDTH(32), .DLY_W(8)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
    edge_stim_gen #(.WIDTH(24), .DLY_W(8)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));

    always #5 clk = ~clk;

    a_rose7: assert property (@(posedge clk) disable iff (rst) $rose(b0.sig_out[7]) == b0.rose_o[7])
        else begin
            fails++;
            $display("FAIL sva_rose7 rose_o[7]=%b disagrees with $rose", b0.rose_o[7]);
        end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [4:0] idx, input logic [7:0] dly, input logic [7:0] hold);
        b0.cmd_valid = 1'b1;
        b0.cmd_op    = op;
        b0.cmd_idx   = idx;
        b0.cmd_dly   = dly;
        b0.cmd_hold  = hold;
        step();
        b0.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        tests++; if (b0.sig_out !== 32'h0) begin fails++; $display("FAIL reset_sig got %h exp 00000000", b0.sig_out); end
        tests++; if ({b0.rose_o, b0.fell_o, b0.done, b0.err} !== 66'h0) begin fails++; $display("FAIL reset_flags got %h exp 0", {b0.rose_o, b0.fell_o, b0.done, b0.err}); end
        rst = 1'b0;
        step();
        tests++; if (b0.cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", b0.cmd_ready); end
    endtask

    task automatic test_rise();
        issue(2'b00, 5'd0, 8'd0, 8'd0);
        tests++; if (b0.cmd_ready !== 1'b0) begin fails++; $display("FAIL rise_busy got %b exp 0", b0.cmd_ready); end
        step();
        tests++; if (b0.sig_out !== 32'h1) begin fails++; $display("FAIL rise_sig got %h exp 00000001", b0.sig_out); end
        tests++; if (b0.rose_o !== 32'h1) begin fails++; $display("FAIL rise_rose got %h exp 00000001", b0.rose_o); end
        tests++; if ({b0.done, b0.err} !== 2'b10) begin fails++; $display("FAIL rise_done got %b exp 10", {b0.done, b0.err}); end
        tests++; if (b0.cmd_ready !== 1'b1) begin fails++; $display("FAIL rise_ready got %b exp 1", b0.cmd_ready); end
    endtask

    task automatic test_fall_delay();
        issue(2'b00, 5'd31, 8'd0, 8'd0);
        step();
        issue(2'b01, 5'd31, 8'd3, 8'd0);
        b0.cmd_valid = 1'b1;
        b0.cmd_op    = 2'b00;
        b0.cmd_idx   = 5'd2;
        b0.cmd_dly   = 8'd0;
        for (int k = 1; k <= 3; k++) begin
            step();
            if (k == 2) b0.cmd_valid = 1'b0;
            tests++; if ({b0.cmd_ready, b0.done} !== 2'b00) begin fails++; $display("FAIL fall_wait%0d ready/done got %b exp 00", k, {b0.cmd_ready, b0.done}); end
            tests++; if (b0.sig_out !== 32'h8000_0001) begin fails++; $display("FAIL fall_hold%0d got %h exp 80000001", k, b0.sig_out); end
        end
        step();
        tests++; if (b0.sig_out !== 32'h1) begin fails++; $display("FAIL fall_sig got %h exp 00000001", b0.sig_out); end
        tests++; if (b0.fell_o !== 32'h8000_0000) begin fails++; $display("FAIL fall_flag got %h exp 80000000", b0.fell_o); end
        tests++; if ({b0.done, b0.err} !== 2'b10) begin fails++; $display("FAIL fall_done got %b exp 10", {b0.done, b0.err}); end
        step();
        tests++; if (b0.sig_out !== 32'h1 || b0.fell_o !== 32'h0) begin fails++; $display("FAIL fall_after got %h/%h exp 00000001/00000000", b0.sig_out, b0.fell_o); end
    endtask

    task automatic test_pulse();
        issue(2'b10, 5'd5, 8'd2, 8'd1);
        step();
        step();
        tests++; if (b0.sig_out !== 32'h1) begin fails++; $display("FAIL pulse_pre got %h exp 00000001", b0.sig_out); end
        step();
        tests++; if (b0.sig_out !== 32'h21 || b0.rose_o !== 32'h20 || b0.done !== 1'b0) begin fails++; $display("FAIL pulse_rise got %h/%h/%b exp 00000021/00000020/0", b0.sig_out, b0.rose_o, b0.done); end
        step();
        tests++; if (b0.sig_out !== 32'h21 || b0.rose_o !== 32'h0 || b0.done !== 1'b0) begin fails++; $display("FAIL pulse_high got %h/%h/%b exp 00000021/00000000/0", b0.sig_out, b0.rose_o, b0.done); end
        step();
        tests++; if (b0.sig_out !== 32'h1 || b0.fell_o !== 32'h20 || b0.done !== 1'b1) begin fails++; $display("FAIL pulse_fall got %h/%h/%b exp 00000001/00000020/1", b0.sig_out, b0.fell_o, b0.done); end
        step();
        tests++; if (b0.fell_o !== 32'h0 || b0.done !== 1'b0) begin fails++; $display("FAIL pulse_after got %h/%b exp 00000000/0", b0.fell_o, b0.done); end
    endtask

    task automatic test_illegal();
        issue(2'b00, 5'd0, 8'd0, 8'd0);
        step();
        tests++; if ({b0.err, b0.done} !== 2'b11 || b0.rose_o !== 32'h0 || b0.sig_out !== 32'h1) begin fails++; $display("FAIL ill_rise got %b/%h/%h exp 11/00000000/00000001", {b0.err, b0.done}, b0.rose_o, b0.sig_out); end
        issue(2'b01, 5'd3, 8'd1, 8'd0);
        step();
        step();
        tests++; if ({b0.err, b0.done} !== 2'b11 || b0.fell_o !== 32'h0 || b0.sig_out !== 32'h1) begin fails++; $display("FAIL ill_fall got %b/%h/%h exp 11/00000000/00000001", {b0.err, b0.done}, b0.fell_o, b0.sig_out); end
        issue(2'b10, 5'd0, 8'd0, 8'd2);
        step();
        tests++; if ({b0.err, b0.done} !== 2'b11 || b0.sig_out !== 32'h1) begin fails++; $display("FAIL ill_pulse got %b/%h exp 11/00000001", {b0.err, b0.done}, b0.sig_out); end
        step();
        tests++; if ({b0.err, b0.done, b0.cmd_ready} !== 3'b001 || b0.fell_o !== 32'h0) begin fails++; $display("FAIL ill_pulse_after got %b/%h exp 001/00000000", {b0.err, b0.done, b0.cmd_ready}, b0.fell_o); end
        b1.cmd_valid = 1'b1;
        b1.cmd_op    = 2'b00;
        b1.cmd_idx   = 5'd30;
        b1.cmd_dly   = 8'd50;
        b1.cmd_hold  = 8'd0;
        step();
        b1.cmd_valid = 1'b0;
        step();
        tests++; if ({b1.err, b1.done} !== 2'b11 || b1.sig_out !== 24'h0 || b1.rose_o !== 24'h0) begin fails++; $display("FAIL ill_idx got %b/%h/%h exp 11/000000/000000", {b1.err, b1.done}, b1.sig_out, b1.rose_o); end
        step();
        tests++; if (b1.cmd_ready !== 1'b1 || b1.sig_out !== 24'h0) begin fails++; $display("FAIL ill_idx_after got %b/%h exp 1/000000", b1.cmd_ready, b1.sig_out); end
    endtask

    task automatic test_reset_mid();
        issue(2'b00, 5'd9, 8'd200, 8'd0);
        repeat (5) step();
        rst = 1'b1;
        #1;
        tests++; if (b0.sig_out !== 32'h0 || b0.done !== 1'b0 || b0.err !== 1'b0) begin fails++; $display("FAIL rstmid_sig got %h/%b/%b exp 00000000/0/0", b0.sig_out, b0.done, b0.err); end
        step();
        rst = 1'b0;
        step();
        tests++; if (b0.cmd_ready !== 1'b1) begin fails++; $display("FAIL rstmid_ready got %b exp 1", b0.cmd_ready); end
        for (int k = 0; k < 8; k++) begin
            step();
            tests++; if (b0.sig_out !== 32'h0 || {b0.done, b0.err} !== 2'b00) begin fails++; $display("FAIL rstmid_quiet%0d got %h/%b exp 00000000/00", k, b0.sig_out, {b0.done, b0.err}); end
        end
    endtask

    task automatic test_back_to_back();
        issue(2'b11, 5'd7, 8'd0, 8'd0);
        step();
        tests++; if (b0.sig_out !== 32'h80 || b0.rose_o !== 32'h80 || b0.done !== 1'b1 || b0.cmd_ready !== 1'b1) begin fails++; $display("FAIL b2b_first got %h/%h/%b/%b exp 00000080/00000080/1/1", b0.sig_out, b0.rose_o, b0.done, b0.cmd_ready); end
        issue(2'b11, 5'd7, 8'd0, 8'd0);
        tests++; if (b0.cmd_ready !== 1'b0 || b0.sig_out !== 32'h80) begin fails++; $display("FAIL b2b_accept got %b/%h exp 0/00000080", b0.cmd_ready, b0.sig_out); end
        step();
        tests++; if (b0.sig_out !== 32'h0 || b0.fell_o !== 32'h80 || b0.rose_o !== 32'h0 || {b0.done, b0.err} !== 2'b10) begin fails++; $display("FAIL b2b_second got %h/%h/%h/%b exp 00000000/00000080/00000000/10", b0.sig_out, b0.fell_o, b0.rose_o, {b0.done, b0.err}); end
    endtask

    initial begin
        b0.cmd_valid = 1'b0;
        b0.cmd_op    = '0;
        b0.cmd_idx   = '0;
        b0.cmd_dly   = '0;
        b0.cmd_hold  = '0;
        b1.cmd_valid = 1'b0;
        b1.cmd_op    = '0;
        b1.cmd_idx   = '0;
        b1.cmd_dly   = '0;
        b1.cmd_hold  = '0;
        test_reset();
        test_rise();
        test_fall_delay();
        test_pulse();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
